mod_add_sub: RTL

- Modular add/subtract unit for the ECDSA verify datapath: computes (a + b) mod M or (a − b) mod M for a 384-bit modulus M.
- Sits directly downstream of the 385-bit pipelined adder. It instantiates one adder, drives its start/subtract/operands, and consumes its result/done.
- Correction is done by a second pass through the same adder.
- Feeds the point-arithmetic controller, which expects fully reduced results in [0, M).

---
 rtl/mod_arith_pkg.sv | 20 ++
 rtl/mod_add_sub_adder.sv | 42 ++++
 rtl/mod_add_sub.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// Shared constants for the modular arithmetic datapath: width, adder latency,
// FSM state encoding and the P-384 prime.
package mod_arith_pkg;

  localparam int WIDTH   = 384;
  localparam int ADD_LAT = 2;

  localparam logic [WIDTH-1:0] P384 =
    384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    WAIT1 = 3'd2,
    PASS2 = 3'd3,
    WAIT2 = 3'd4,
    FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/mod_add_sub_adder.sv
// Pipelined (W+1)-bit add/subtract: result[W] is carry on add, borrow on sub.
// done_o follows start_i by LAT cycles.
module mod_add_sub_adder
  import mod_arith_pkg::*;
#(
  parameter int W   = WIDTH,
  parameter int LAT = ADD_LAT
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   result_o,
  output logic         done_o
);

  logic [LAT-1:0]      vld_pipe;
  logic [LAT-1:0][W:0] dat_pipe;
  logic [W:0]          sum;

  assign sum = sub_i ? ({1'b0, a_i} - {1'b0, b_i}) : ({1'b0, a_i} + {1'b0, b_i});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= start_i;
      dat_pipe[0] <= sum;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign done_o   = vld_pipe[LAT-1];
  assign result_o = dat_pipe[LAT-1];

endmodule

// File: rtl/mod_add_sub.sv
// (a +/- b) mod M via two passes through one pipelined adder.
// Optional MOD_ADD_SUB_EARLY_DONE_EN: skip the correction pass for borrow-free subtracts.
module mod_add_sub
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = mod_arith_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  if (WIDTH != mod_arith_pkg::WIDTH) begin : g_cfg_err
    $error("mod_add_sub: WIDTH must equal the adder operand width");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, m_q, r1_q, r2_q, result_q, res_d;
  logic             sub_q, f1_q, f2_q, done_q, done_d;
  logic             add_start, add_sub, add_done, accept;
  logic [WIDTH-1:0] add_a, add_b;
  logic [WIDTH:0]   add_res;

  mod_add_sub_adder #(.W(WIDTH), .LAT(ADD_LAT)) u_adder (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (add_start),
    .sub_i    (add_sub),
    .a_i      (add_a),
    .b_i      (add_b),
    .result_o (add_res),
    .done_o   (add_done)
  );

  // The done cycle is already IDLE; holding off until it passes makes the
  // earliest accepted follow-on request the cycle after done.
  assign accept = (state_q == IDLE) && start && !done_q;

  always_comb begin
    state_d   = state_q;
    add_start = 1'b0;
    add_sub   = sub_q;
    add_a     = a_q;
    add_b     = b_q;
    res_d     = result_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = PASS1;
      PASS1: begin
        add_start = 1'b1;
        state_d   = WAIT1;
      end
      WAIT1: if (add_done) begin
`ifdef MOD_ADD_SUB_EARLY_DONE_EN
        state_d = (sub_q && !add_res[WIDTH]) ? FIN : PASS2;
`else
        state_d = PASS2;
`endif
      end
      PASS2: begin
        add_start = 1'b1;
        add_a     = r1_q;
        add_b     = m_q;
        add_sub   = ~sub_q;
        state_d   = WAIT2;
      end
      WAIT2: if (add_done) state_d = FIN;
      FIN: begin
        // add: carry or no borrow on r1-M means r1 >= M; sub: borrow means add M back
        if (sub_q) res_d = f1_q ? r2_q : r1_q;
        else       res_d = (f1_q | ~f2_q) ? r2_q : r1_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      sub_q    <= 1'b0;
      r1_q     <= '0;
      f1_q     <= 1'b0;
      r2_q     <= '0;
      f2_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= res_d;
      done_q   <= done_d;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        m_q   <= in_m;
        sub_q <= subtract;
      end
      if (state_q == WAIT1 && add_done) begin
        r1_q <= add_res[WIDTH-1:0];
        f1_q <= add_res[WIDTH];
      end
      if (state_q == WAIT2 && add_done) begin
        r2_q <= add_res[WIDTH-1:0];
        f2_q <= add_res[WIDTH];
      end
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE) || done_q;

endmodule
